// File: rtl/fibonacci_index_decoder.sv
// fibonacci_index_decoder
//
// Inverse of the Fibonacci generator: given an unsigned target N, walks the
// recurrence F0=0, F1=1, F(k+2)=F(k)+F(k+1), one term per clock, and reports
// whether N is a Fibonacci number and at which index.
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous, active-low reset
//   start   request, sampled only while the FSM is idle
//   N       target value, latched on an accepted start
//   ready   high while idle
//   busy    high while searching
//   done    one-cycle completion pulse
//   is_fib  1 when N equals some F(k)
//   index   smallest k with F(k) == N, or the first k with F(k) > N
//
// Result semantics
//   N=1 matches F1 before F2 is ever visited, so the smallest index is
//   reported without any special casing.
//   is_fib/index are captured on the final comparison and hold until the next
//   completed search; a reset clears them and discards an aborted search.
//
// Timing
//   ready/busy/done are registered copies of the FSM state, one cycle behind
//   it. For a start accepted at edge t with result index k, busy is high for
//   k+1 cycles and done pulses in the cycle after edge t+2+k (latency k+2).
//   No combinational path exists from start or N to any output.

module fibonacci_index_decoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             is_fib,
  output logic [IDX_W-1:0] index
);

  // Two guard bits: a <= 2^WIDTH-1 while the search continues, and
  // b < 2*a + 2 < 2^(WIDTH+2), so a+b cannot wrap before termination.
  localparam int unsigned AccW = WIDTH + 2;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Recurrence registers: a = F(k), b = F(k+1).
  logic [AccW-1:0]  a_q, a_d;
  logic [AccW-1:0]  b_q, b_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;

  // Result registers.
  logic             is_fib_q, is_fib_d;
  logic [IDX_W-1:0] index_q, index_d;

  // Status outputs, registered from the current state.
  logic ready_q, busy_q, done_q;

  logic [AccW-1:0] tgt_ext;
  logic            hit;
  logic            over;

  assign tgt_ext = AccW'(tgt_q);
  assign hit     = (a_q == tgt_ext);
  assign over    = (a_q > tgt_ext);

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    tgt_d    = tgt_q;
    is_fib_d = is_fib_q;
    index_d  = index_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tgt_d   = N;
          a_d     = '0;
          b_d     = AccW'(1);
          k_d     = '0;
          state_d = StSearch;
        end
      end

      StSearch: begin
        if (hit) begin
          is_fib_d = 1'b1;
          index_d  = k_q;
          state_d  = StDone;
        end else if (over) begin
          // k is the index of the first term exceeding the target.
          is_fib_d = 1'b0;
          index_d  = k_q;
          state_d  = StDone;
        end else begin
          a_d = b_q;
          b_d = a_q + b_q;
          k_d = k_q + IDX_W'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM and datapath state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      tgt_q    <= '0;
      is_fib_q <= 1'b0;
      index_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      tgt_q    <= tgt_d;
      is_fib_q <= is_fib_d;
      index_q  <= index_d;
    end
  end

  // Status flops trail the FSM by one cycle, which places done after the
  // result registers have settled and gives the k+2 start-to-done latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (state_q == StIdle);
      busy_q  <= (state_q == StSearch);
      done_q  <= (state_q == StDone);
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign is_fib = is_fib_q;
  assign index  = index_q;

endmodule

// File: tb/tb_fibonacci_index_decoder.sv
// Self-checking bench for fibonacci_index_decoder (WIDTH=8, IDX_W=5).
// Expected results come from a plain-arithmetic Fibonacci walk in ref_model.

module tb_fibonacci_index_decoder;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] N;
  logic       ready;
  logic       busy;
  logic       done;
  logic       is_fib;
  logic [4:0] index;

  int n_checks;
  int n_fail;

  fibonacci_index_decoder #(
    .WIDTH(8),
    .IDX_W(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .N     (N),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .is_fib(is_fib),
    .index (index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Smallest k with F(k) >= n; fib says whether it is an exact match.
  function automatic void ref_model(input int n, output bit fib, output int idx);
    longint fa;
    longint fb;
    longint t;
    fa  = 0;
    fb  = 1;
    idx = 0;
    while (fa < n) begin
      t  = fa + fb;
      fa = fb;
      fb = t;
      idx++;
    end
    fib = (fa == longint'(n));
  endfunction

  // Issue one start pulse and observe until one cycle past done.
  // lat is the number of cycles from the start edge to the first done sample.
  task automatic run_search(input logic [7:0] n, output logic fib, output logic [4:0] idx,
                            output int lat, output int busy_cnt, output int done_cnt);
    fib      = 1'bx;
    idx      = 'x;
    lat      = -1;
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    N     = n;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = cyc;
          fib = is_fib;
          idx = index;
        end
      end
      if (lat >= 0 && cyc == lat + 1) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    N     = '0;
    #23;
    n_checks += 5;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    if (is_fib !== 1'b0) begin n_fail++; $display("FAIL reset_is_fib: got %b expected 0", is_fib); end
    if (index !== 5'd0) begin n_fail++; $display("FAIL reset_index: got %0d expected 0", index); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic       fib;
    logic [4:0] idx;
    int         lat, bc, dc;
    run_search(8'd13, fib, idx, lat, bc, dc);
    n_checks += 5;
    if (fib !== 1'b1) begin n_fail++; $display("FAIL basic13_is_fib: got %b expected 1", fib); end
    if (idx !== 5'd7) begin n_fail++; $display("FAIL basic13_index: got %0d expected 7", idx); end
    if (lat != 9) begin n_fail++; $display("FAIL basic13_latency: got %0d expected 9", lat); end
    if (bc != 8) begin n_fail++; $display("FAIL basic13_busy_cycles: got %0d expected 8", bc); end
    if (dc != 1) begin n_fail++; $display("FAIL basic13_done_cycles: got %0d expected 1", dc); end
  endtask

  task automatic test_boundaries();
    logic [7:0] vals  [5] = '{8'd0, 8'd1, 8'd4, 8'd255, 8'd233};
    logic [4:0] eidx  [5] = '{5'd0, 5'd1, 5'd5, 5'd14, 5'd13};
    logic       efib  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       fib;
    logic [4:0] idx;
    int         lat, bc, dc;
    for (int i = 0; i < 5; i++) begin
      run_search(vals[i], fib, idx, lat, bc, dc);
      n_checks += 3;
      if (fib !== efib[i]) begin
        n_fail++; $display("FAIL bound_is_fib N=%0d: got %b expected %b", vals[i], fib, efib[i]);
      end
      if (idx !== eidx[i]) begin
        n_fail++; $display("FAIL bound_index N=%0d: got %0d expected %0d", vals[i], idx, eidx[i]);
      end
      if (lat != int'(eidx[i]) + 2) begin
        n_fail++;
        $display("FAIL bound_latency N=%0d: got %0d expected %0d", vals[i], lat, eidx[i] + 2);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic       fib;
    logic [4:0] idx;
    int         lat;
    fib = 1'bx;
    idx = 'x;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    N     = 8'd144;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 3) begin start = 1'b1; N = 8'd2; end
      if (cyc == 4) start = 1'b0;
      if (done && lat < 0) begin
        lat = cyc;
        fib = is_fib;
        idx = index;
      end
      if (lat >= 0 && cyc == lat + 1) break;
    end
    n_checks += 3;
    if (fib !== 1'b1) begin n_fail++; $display("FAIL ignore_is_fib: got %b expected 1", fib); end
    if (idx !== 5'd12) begin n_fail++; $display("FAIL ignore_index: got %0d expected 12", idx); end
    if (lat != 14) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 14", lat); end
  endtask

  task automatic test_reset_abort();
    logic       fib;
    logic [4:0] idx;
    int         lat, bc, dc;
    bit         saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    N     = 8'd89;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks += 5;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", ready); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
    if (is_fib !== 1'b0) begin n_fail++; $display("FAIL abort_is_fib: got %b expected 0", is_fib); end
    if (index !== 5'd0) begin n_fail++; $display("FAIL abort_index: got %0d expected 0", index); end
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
      if (cyc == 2) reset = 1'b1;
    end
    n_checks++;
    if (saw_done) begin n_fail++; $display("FAIL abort_no_done: got 1 expected 0"); end
    run_search(8'd89, fib, idx, lat, bc, dc);
    n_checks += 2;
    if (fib !== 1'b1) begin n_fail++; $display("FAIL abort_rerun_is_fib: got %b expected 1", fib); end
    if (idx !== 5'd11) begin n_fail++; $display("FAIL abort_rerun_index: got %0d expected 11", idx); end
  endtask

  task automatic test_back_to_back();
    bit         f1, f2;
    int         k1, k2;
    int         d1, d2, b2;
    logic [4:0] i1, i2;
    logic       fb2;
    ref_model(21, f1, k1);
    ref_model(50, f2, k2);
    d1 = -1; d2 = -1; b2 = -1;
    i1 = 'x; i2 = 'x; fb2 = 1'bx;
    @(negedge clk);
    start = 1'b1;
    N     = 8'd21;
    @(posedge clk);
    #1 N = 8'd50;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk);
      #1;
      if (d1 >= 0 && cyc == d1 + 1) start = 1'b0;
      if (d1 >= 0 && b2 < 0 && busy) b2 = cyc;
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc;
          i1 = index;
        end else if (d2 < 0 && cyc > d1) begin
          d2  = cyc;
          i2  = index;
          fb2 = is_fib;
        end
      end
      if (d2 >= 0) break;
    end
    start = 1'b0;
    n_checks += 6;
    if (d1 != k1 + 2) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", d1, k1 + 2); end
    if (i1 !== 5'(k1)) begin n_fail++; $display("FAIL b2b_first_index: got %0d expected %0d", i1, k1); end
    if (b2 - d1 != 2) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 2", b2 - d1); end
    if (d2 != k1 + k2 + 5) begin
      n_fail++; $display("FAIL b2b_second_done: got %0d expected %0d", d2, k1 + k2 + 5);
    end
    if (i2 !== 5'(k2)) begin n_fail++; $display("FAIL b2b_second_index: got %0d expected %0d", i2, k2); end
    if (fb2 !== f2) begin n_fail++; $display("FAIL b2b_second_is_fib: got %b expected %b", fb2, f2); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_sweep();
    bit         efib;
    int         eidx;
    logic       fib;
    logic [4:0] idx;
    int         lat, bc, dc;
    for (int n = 0; n < 256; n++) begin
      ref_model(n, efib, eidx);
      run_search(8'(n), fib, idx, lat, bc, dc);
      n_checks += 5;
      if (fib !== efib) begin n_fail++; $display("FAIL sweep_is_fib N=%0d: got %b expected %b", n, fib, efib); end
      if (idx !== 5'(eidx)) begin n_fail++; $display("FAIL sweep_index N=%0d: got %0d expected %0d", n, idx, eidx); end
      if (lat != eidx + 2) begin n_fail++; $display("FAIL sweep_latency N=%0d: got %0d expected %0d", n, lat, eidx + 2); end
      if (dc != 1) begin n_fail++; $display("FAIL sweep_done_width N=%0d: got %0d expected 1", n, dc); end
      if (bc != eidx + 1) begin n_fail++; $display("FAIL sweep_busy N=%0d: got %0d expected %0d", n, bc, eidx + 1); end
    end
  endtask

  task automatic test_random();
    bit         efib;
    int         eidx;
    int         n;
    logic       fib;
    logic [4:0] idx;
    int         lat, bc, dc;
    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(0, 255));
      ref_model(n, efib, eidx);
      run_search(8'(n), fib, idx, lat, bc, dc);
      n_checks += 3;
      if (fib !== efib) begin n_fail++; $display("FAIL rand_is_fib N=%0d: got %b expected %b", n, fib, efib); end
      if (idx !== 5'(eidx)) begin n_fail++; $display("FAIL rand_index N=%0d: got %0d expected %0d", n, idx, eidx); end
      if (lat != eidx + 2) begin n_fail++; $display("FAIL rand_latency N=%0d: got %0d expected %0d", n, lat, eidx + 2); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
